// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
// Shared definitions for the UART word transmit scheduler:
//   state_t     - scheduler FSM encoding
//   HEADER_BASE - base value of the optional per-word header byte
//   idx_width   - bit width needed to hold a requester index
package uart_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2
  } state_t;

  localparam logic [7:0] HEADER_BASE = 8'hA0;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick. Searches upward from ptr_i+1 with
// wraparound and returns the first requesting index as a one-hot grant.
// The caller owns and updates the pointer register.
// Ports:
//   req_i   [N_REQ-1:0]  request vector
//   ptr_i   [IW-1:0]     index of the previous winner
//   gnt_o   [N_REQ-1:0]  one-hot grant (zero when nothing requested)
//   valid_o              at least one request present
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  always_comb begin
    int  idx;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    // k runs 1..N_REQ so the previous winner is considered last
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_word_tx_sched.sv
// uart_word_tx_sched
// Shares one byte-wide UART transmitter among N_REQ word producers.
// Grants one requester at a time (round robin), latches its 32-bit word
// and sends BYTES_PER_WORD bytes LSB first through tx_start/tx_busy.
// Optional build macro: UART_SCHED_HEADER_EN - prefix each word with a
// header byte HEADER_BASE | granted_index.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req        per-requester word pending (held until ack)
//   wdata      requester i word at [32i+31:32i]
//   ack        one-cycle pulse, word of requester i latched
//   busy       a word is in flight
//   sdata      byte to transmitter
//   tx_start   one-cycle start pulse to transmitter
//   tx_busy    transmitter busy (rises the cycle after tx_start)
//
// state     | meaning
// S_IDLE    | waiting for a request with the transmitter idle
// S_WAIT_HI | byte started, waiting for tx_busy to rise
// S_WAIT_LO | byte in transmitter, waiting for tx_busy to fall
module uart_word_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  wdata,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic [7:0]           sdata,
  output logic                 tx_start,
  input  logic                 tx_busy
);

  localparam int IW = idx_width(N_REQ);
`ifdef UART_SCHED_HEADER_EN
  localparam logic [2:0] HDR = 3'd1;
`else
  localparam logic [2:0] HDR = 3'd0;
`endif
  localparam logic [2:0] LAST = 3'(BYTES_PER_WORD) + HDR - 3'd1;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [7:0]        sdata_q, sdata_d;
  logic              tx_start_q, tx_start_d;

  logic [N_REQ-1:0]  gnt;
  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;
  logic [31:0]       gnt_word;
  logic              grant;
  logic [2:0]        nxt_k;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [2:0] k);
    logic [31:0] s;
    s = w >> {k[1:0], 3'b000};
    return s[7:0];
  endfunction

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = IW'(i);
        gnt_word = wdata[32*i +: 32];
      end
    end
  end

  // A grant also needs the transmitter idle, which covers a byte left
  // running by a reset in the middle of a word.
  assign grant = (state_q == S_IDLE) && gnt_valid && !tx_busy;
  // Data byte index for the next byte; the header, when present, occupies count 0.
  assign nxt_k = cnt_q + 3'd1 - HDR;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= IW'(N_REQ - 1);
      wbuf_q     <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      sdata_q    <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wbuf_q     <= wbuf_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      sdata_q    <= sdata_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant) state_d = S_WAIT_HI;
      S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!tx_busy) state_d = (cnt_q == LAST) ? S_IDLE : S_WAIT_HI;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ptr_d      = ptr_q;
    wbuf_d     = wbuf_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    busy_d     = busy_q;
    sdata_d    = sdata_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          ack_d      = gnt;
          wbuf_d     = gnt_word;
          ptr_d      = gnt_idx;
          busy_d     = 1'b1;
          cnt_d      = '0;
          tx_start_d = 1'b1;
`ifdef UART_SCHED_HEADER_EN
          sdata_d    = HEADER_BASE | 8'(gnt_idx);
`else
          sdata_d    = word_byte(gnt_word, 3'd0);
`endif
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (cnt_q == LAST) begin
            busy_d = 1'b0;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            sdata_d    = word_byte(wbuf_q, nxt_k);
            tx_start_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign sdata    = sdata_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_word_tx_sched.sv
// Testbench for uart_word_tx_sched (N_REQ=2, BYTES_PER_WORD=4).
// Expected grants and bytes are queued as stimulus is issued; a monitor
// pops and compares whenever the DUT pulses ack or tx_start.
// Honours UART_SCHED_HEADER_EN the same way as the design.
module tb_uart_word_tx_sched;

  localparam int BUSY_CYC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  ack;
  logic        busy;
  logic [7:0]  sdata;
  logic        tx_start;
  logic        tx_busy;
  logic        model_busy = 1'b0;
  logic        ext_busy = 1'b0;

  assign tx_busy = model_busy | ext_busy;

  always #5 clk = ~clk;

  uart_word_tx_sched #(.N_REQ(2), .BYTES_PER_WORD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .ack      (ack),
    .busy     (busy),
    .sdata    (sdata),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fall = -100;
  int tx_start_cnt = 0;
  int ack_cnt = 0;
  bit b2b_en = 1'b0;
  int b2b_acks = 0;
  logic [7:0] exp_bytes[$];
  int         exp_acks[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input int idx, input logic [31:0] w);
    exp_acks.push_back(idx);
`ifdef UART_SCHED_HEADER_EN
    exp_bytes.push_back(8'hA0 | 8'(idx));
`endif
    for (int k = 0; k < 4; k++) exp_bytes.push_back(w[8*k +: 8]);
  endtask

  task automatic wait_done(input string name);
    int t;
    for (t = 0; t < 3000; t++) begin
      if (exp_bytes.size() == 0 && exp_acks.size() == 0 && !busy && !tx_busy) break;
      tick();
    end
    check(name, (t >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_acks(input string name, input int target);
    int t;
    for (t = 0; t < 3000; t++) begin
      if (ack_cnt >= target) break;
      tick();
    end
    check(name, (t >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_starts(input string name, input int target);
    int t;
    for (t = 0; t < 3000; t++) begin
      if (tx_start_cnt >= target) break;
      tick();
    end
    check(name, (t >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sdata"}, 32'(sdata), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
  endtask

  // Transmitter model: busy for BUSY_CYC cycles starting the cycle after tx_start.
  initial begin
    int cnt;
    bit sp;
    cnt = 0;
    sp  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) model_busy = 1'b0;
      end
      if (sp) begin
        model_busy = 1'b1;
        cnt = BUSY_CYC;
      end
      sp = tx_start;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic pb, ps, pbusy, prst;
    int   idx;
    pb = 1'b0; ps = 1'b0; pbusy = 1'b0; prst = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (pb && !tx_busy) last_fall = cyc;
      if (|ack) begin
        check("ack_onehot", 32'($onehot(ack)), 32'd1);
        check("ack_with_start", 32'(tx_start), 32'd1);
        idx = ack[1] ? 1 : 0;
        if (exp_acks.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ack_unexpected: got ack %b expected none (cycle %0d)", ack, cyc);
        end else begin
          check("ack_idx", 32'(idx), 32'(exp_acks.pop_front()));
        end
        ack_cnt++;
        if (b2b_en) begin
          if (b2b_acks > 0) check("b2b_latency", 32'(cyc - last_fall), 32'd2);
          b2b_acks++;
        end
      end
      if (tx_start) begin
        tx_start_cnt++;
        check("start_width", 32'(ps), 32'd0);
        check("start_vs_busy", 32'(tx_busy), 32'd0);
        if (!(|ack)) check("byte_gap", 32'(cyc - last_fall), 32'd1);
        if (exp_bytes.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL start_unexpected: got sdata %0h expected no tx_start (cycle %0d)", sdata, cyc);
        end else begin
          check("sdata", 32'(sdata), 32'(exp_bytes.pop_front()));
        end
      end
      if (pbusy && !busy && !prst) check("busy_fall", 32'(cyc - last_fall), 32'd1);
      pb = tx_busy; ps = tx_start; pbusy = busy; prst = rst;
    end
  end

  // Stimulus
  initial begin
    int base;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // Contention: both held, expect 0,1,0,1 from reset pointer
    b2b_en = 1'b1;
    wdata = {32'hBBBB1111, 32'hAAAA0000};
    push_word(0, 32'hAAAA0000);
    push_word(1, 32'hBBBB1111);
    push_word(0, 32'hAAAA0000);
    push_word(1, 32'hBBBB1111);
    base = ack_cnt;
    req = 2'b11;
    wait_acks("contention_ack_timeout", base + 4);
    req = 2'b00;
    wait_done("contention_done_timeout");
    b2b_en = 1'b0;

    // Single request
    wdata[31:0] = 32'h44332211;
    push_word(0, 32'h44332211);
    base = ack_cnt;
    req = 2'b01;
    wait_acks("single_ack_timeout", base + 1);
    req = 2'b00;
    wait_done("single_done_timeout");
    check("single_ack_count", 32'(ack_cnt - base), 32'd1);

    // Transmitter busy when request arrives
    ext_busy = 1'b1;
    tick();
    wdata[31:0] = 32'hDEADBEEF;
    push_word(0, 32'hDEADBEEF);
    req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy_no_ack", 32'(ack), 32'd0);
    end
    tick();
    ext_busy = 1'b0;
    @(negedge clk);
    check("busy_release_no_ack_yet", 32'(ack), 32'd0);
    @(negedge clk);
    check("busy_release_ack", 32'(ack), 32'd1);
    tick();
    req = 2'b00;
    wait_done("idle_busy_done_timeout");

    // Requester 1 word (header A1 first when enabled)
    wdata[63:32] = 32'h04030201;
    push_word(1, 32'h04030201);
    base = ack_cnt;
    req = 2'b10;
    wait_acks("req1_ack_timeout", base + 1);
    req = 2'b00;
    wait_done("req1_done_timeout");

    // Reset after the second byte starts
    wdata[31:0] = 32'h88776655;
    push_word(0, 32'h88776655);
    base = tx_start_cnt;
    req = 2'b01;
    wait_starts("rst_first_start_timeout", base + 1);
    req = 2'b00;
    wait_starts("rst_second_start_timeout", base + 2);
    rst = 1'b1;
    exp_bytes.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midword_reset");
    repeat (60) tick();
    check("no_start_after_reset", 32'(tx_start_cnt - base), 32'd2);
    check("idle_after_reset", 32'(busy), 32'd0);

    check("acks_left", 32'(exp_acks.size()), 32'd0);
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
